// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and system reset sequencer.
// Holds rst_out until lock is stable, then releases it after a hold phase.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pll_locked,
    input  logic                 sw_rst_req,
    output logic                 rst_out,
    output logic                 ready,
    output logic [1:0]           state_o,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        STABLE = 2'd1,
        HOLD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int PW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [PW-1:0] LOCK_LAST = PW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LAST = PW'(RESET_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    state_t                 state;
    state_t                 nxt;
    logic [PW-1:0]          phase;
    logic                   loss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync[SYNC_STAGES-1];

    always_comb begin
        nxt  = state;
        loss = 1'b0;
        case (state)
            WAIT: begin
                if (locked_s) nxt = STABLE;
            end
            STABLE: begin
                if (!locked_s)               nxt = WAIT;
                else if (phase == LOCK_LAST) nxt = HOLD;
            end
            HOLD: begin
                if (!locked_s)               nxt = WAIT;
                else if (phase == HOLD_LAST) nxt = RUN;
            end
            RUN: begin
                // lock loss takes priority over a soft-reset request
                if (!locked_s) begin
                    nxt  = WAIT;
                    loss = 1'b1;
                end else if (sw_rst_req) begin
                    nxt = HOLD;
                end
            end
            default: nxt = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WAIT;
            phase         <= '0;
            rst_out       <= 1'b1;
            ready         <= 1'b0;
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state   <= nxt;
            rst_out <= (nxt != RUN);
            ready   <= (nxt == RUN);
            if (nxt != state || state == WAIT || state == RUN) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
            if (loss) begin
                lock_lost <= 1'b1;
                if (lock_loss_cnt != '1) begin
                    lock_loss_cnt <= lock_loss_cnt + 1'b1;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed vector table, async reset
// check and randomized lock/soft-reset traffic against a countdown model.
module tb_pll_reset_sequencer;

    localparam int S  = 2;
    localparam int L  = 8;
    localparam int H  = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pll_locked = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic          rst_out;
    logic          ready;
    logic [1:0]    state_o;
    logic          lock_lost;
    logic [CW-1:0] lock_loss_cnt;

    pll_reset_sequencer #(
        .SYNC_STAGES(S),
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES(H),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .rst_out(rst_out),
        .ready(ready),
        .state_o(state_o),
        .lock_lost(lock_lost),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: rem counts edges left until RUN while qualifying
    int mstate;
    int rem;
    int mcnt;
    bit mlost;
    bit msync [S];

    typedef struct {
        bit locked;
        bit sw;
        int n;
        int st;
        bit rst;
        bit rdy;
        bit lost;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic model_reset();
        mstate = 0;
        rem    = 0;
        mcnt   = 0;
        mlost  = 1'b0;
        for (int i = 0; i < S; i++) msync[i] = 1'b0;
    endtask

    task automatic model_edge();
        bit ls;
        ls = msync[S-1];
        if (mstate == 3) begin
            if (!ls) begin
                mstate = 0;
                mlost  = 1'b1;
                if (mcnt < CMAX) mcnt = mcnt + 1;
            end else if (sw_rst_req) begin
                mstate = 2;
                rem    = H;
            end
        end else if (mstate == 0) begin
            if (ls) begin
                mstate = 1;
                rem    = L + H;
            end
        end else begin
            if (!ls) begin
                mstate = 0;
            end else begin
                rem = rem - 1;
                mstate = (rem == 0) ? 3 : ((rem > H) ? 1 : 2);
            end
        end
        for (int i = S - 1; i > 0; i--) msync[i] = msync[i-1];
        msync[0] = pll_locked;
    endtask

    task automatic check(string name, int st, bit r, bit rd, bit lo, int c);
        tests++;
        if ({state_o, rst_out, ready, lock_lost, lock_loss_cnt} !==
            {2'(st), r, rd, lo, CW'(c)}) begin
            fails++;
            $display("FAIL %s: got state=%0d rst=%b ready=%b lost=%b cnt=%0d, want state=%0d rst=%b ready=%b lost=%b cnt=%0d",
                     name, state_o, rst_out, ready, lock_lost, lock_loss_cnt,
                     st, r, rd, lo, c);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", mstate, mstate != 3, mstate == 3, mlost, mcnt);
    endtask

    initial begin
        tbl.push_back('{1, 0, 14, 2, 1, 0, 0, 0});
        tbl.push_back('{1, 0,  1, 3, 0, 1, 0, 0});
        tbl.push_back('{0, 0,  2, 3, 0, 1, 0, 0});
        tbl.push_back('{0, 0,  1, 0, 1, 0, 1, 1});
        tbl.push_back('{1, 0, 14, 2, 1, 0, 1, 1});
        tbl.push_back('{1, 0,  1, 3, 0, 1, 1, 1});
        tbl.push_back('{1, 1,  1, 2, 1, 0, 1, 1});
        tbl.push_back('{1, 0,  3, 2, 1, 0, 1, 1});
        tbl.push_back('{1, 0,  1, 3, 0, 1, 1, 1});
        tbl.push_back('{0, 0,  2, 3, 0, 1, 1, 1});
        tbl.push_back('{0, 1,  1, 0, 1, 0, 1, 2});
        tbl.push_back('{1, 0, 15, 3, 0, 1, 1, 2});
        tbl.push_back('{0, 0,  3, 0, 1, 0, 1, 3});
        tbl.push_back('{1, 0,  5, 1, 1, 0, 1, 3});
        tbl.push_back('{0, 0,  1, 1, 1, 0, 1, 3});
        tbl.push_back('{1, 0,  2, 0, 1, 0, 1, 3});
        tbl.push_back('{1, 0, 12, 2, 1, 0, 1, 3});
        tbl.push_back('{1, 0,  1, 3, 0, 1, 1, 3});
        tbl.push_back('{0, 0,  3, 0, 1, 0, 1, 3});
        tbl.push_back('{1, 0, 15, 3, 0, 1, 1, 3});
        tbl.push_back('{0, 0,  3, 0, 1, 0, 1, 3});
        tbl.push_back('{1, 0, 13, 2, 1, 0, 1, 3});

        model_reset();
        reset = 1'b1;
        #12;
        check("reset_state", 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            pll_locked = tbl[i].locked;
            sw_rst_req = tbl[i].sw;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].rst,
                  tbl[i].rdy, tbl[i].lost, tbl[i].cnt);
        end
        sw_rst_req = 1'b0;

        // mid-HOLD, between edges: reset must act without a clock edge
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 1, 0, 0, 0);
        model_reset();
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            pll_locked = ($urandom_range(0, 99) < 96);
            sw_rst_req = ($urandom_range(0, 19) == 0);
            step();
        end
        sw_rst_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper. Consumes its output clock and its asynchronous `locked` flag.
- Produces the processor's system reset. Holds that reset asserted until lock has been stable for a programmable time, then releases it synchronously.
- Re-asserts the reset on any loss of lock. Keeps a sticky loss flag and a saturating loss counter for debug LEDs.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchroniser (legal >= 2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before the hold phase (legal >= 1)
RESET_HOLD_CYCLES, 16, cycles rst_out stays asserted after lock is qualified (legal >= 1)
CNT_WIDTH, 8, width of lock_loss_cnt

Ports:
clk  input  1  system clock (PLL clk_out)
reset  input  1  asynchronous, active-high reset
pll_locked  input  1  PLL LOCK, asynchronous to clk
sw_rst_req  input  1  synchronous single-cycle soft-reset request
rst_out  output  1  active-high system reset, registered
ready  output  1  high only in RUN, registered
state_o  output  2  current state: WAIT=0, STABLE=1, HOLD=2, RUN=3
lock_lost  output  1  sticky, set on any lock loss while in RUN
lock_loss_cnt  output  CNT_WIDTH  saturating count of lock losses from RUN

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=WAIT, rst_out=1, ready=0, lock_lost=0, lock_loss_cnt=0.
  - Synchroniser flops=0; phase counter=0.
  - Reset asserted mid-operation forces all of the above immediately, regardless of clock.
- Synchroniser: pll_locked passes through SYNC_STAGES flops. locked_s is the last stage. No other logic samples pll_locked directly.
- Phase counter: one shared counter, sized for max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES). Cleared on every state change.
- WAIT: if locked_s=1, go to STABLE.
- STABLE:
  - If locked_s=0, go to WAIT (no loss counted).
  - Else if counter==LOCK_STABLE_CYCLES-1, go to HOLD.
  - Else increment the counter.
- HOLD:
  - If locked_s=0, go to WAIT (no loss counted).
  - Else if counter==RESET_HOLD_CYCLES-1, go to RUN.
  - Else increment the counter.
- RUN:
  - If locked_s=0, go to WAIT, set lock_lost, and increment lock_loss_cnt (saturates at 2^CNT_WIDTH-1, never wraps).
  - Else if sw_rst_req=1, go to HOLD (re-reset without re-qualifying lock).
- Simultaneous events: locked_s=0 together with sw_rst_req in RUN means lock loss wins. sw_rst_req outside RUN is ignored.
- Output encoding: rst_out, ready and state_o are registered from next-state. rst_out = (next_state != RUN) and ready = (next_state == RUN), so the outputs change on the same edge as the state.
- Release latency: edge 1 is the first edge sampling pll_locked=1. rst_out falls at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES (1043 with defaults).
- Assert latency: edge 1 is the first edge sampling pll_locked=0 in RUN. rst_out rises at edge SYNC_STAGES+1.
- Soft reset: sw_rst_req in RUN asserts rst_out on the next edge for exactly RESET_HOLD_CYCLES cycles.
- Glitches: a pll_locked low pulse shorter than one clk period may be missed. That is acceptable. Any low seen on locked_s is honoured.

Test Plan:
1. Params SYNC=2, LOCK=8, HOLD=4. Assert reset, release, raise pll_locked before edge 1 -> rst_out=1 through edge 14; rst_out=0, ready=1, state_o=3 at edge 15.
2. Same params, locked_s drops for 1 cycle while in STABLE -> state returns to WAIT. Full 8+4 qualification restarts. lock_lost=0, lock_loss_cnt=0.
3. In RUN, drop pll_locked -> rst_out=1 and state_o=0 at edge 3 after first low sample; lock_lost=1, lock_loss_cnt=1. Re-lock -> release again after 15 edges.
4. CNT_WIDTH=2, perform 5 lock losses from RUN -> lock_loss_cnt=3 (saturated); lock_lost stays 1 until reset.
5. In RUN, pulse sw_rst_req -> rst_out=1 for exactly 4 cycles, then 0. Repeat with pll_locked dropped the same cycle -> state WAIT, lock_loss_cnt increments.
6. Assert reset asynchronously mid-HOLD, between clk edges -> rst_out=1, ready=0, counters 0 immediately, with no clk edge needed.
